// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the serial FIR engine: default parameter values,
//   the engine FSM state encoding and a ceiling-log2 helper used for address
//   and accumulator sizing.
package fir_pkg;

  localparam int DEF_WC       = 18;  // coefficient width, signed
  localparam int DEF_NUM_COEF = 17;  // number of taps (= coefficient ROM depth)
  localparam int DEF_WIN      = 16;  // input sample width, signed

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ceil(log2(value)), never less than 1 so an address port always exists
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_mac_seq_if.sv
// fir_coef_mac_seq_if
//   Bundles the sample input handshake, the coefficient ROM read port and the
//   filter result of the serial FIR engine.
//   Signals:
//     x_in     Win   signed input sample
//     x_valid  1     sample strobe
//     ready    1     engine can take a sample
//     rom_addr AW    coefficient address to the ROM
//     rom_data Wc    signed coefficient, valid one cycle after rom_addr
//     y_out    Wacc  signed filter result, held until the next result
//     y_valid  1     one-cycle pulse when y_out updates
//   Handshake: a sample is transferred on a rising clock edge where both
//   x_valid and ready are 1; x_valid with ready=0 transfers nothing and the
//   sample is lost (the source is not back-pressured).
//   Modports: master = FIR engine, slave = surrounding environment.
interface fir_coef_mac_seq_if #(
  parameter int Wc       = fir_pkg::DEF_WC,
  parameter int Num_coef = fir_pkg::DEF_NUM_COEF,
  parameter int Win      = fir_pkg::DEF_WIN
);
  localparam int AW   = fir_pkg::clog2(Num_coef);
  localparam int Wacc = Win + Wc + AW;

  logic signed [Win-1:0]  x_in;
  logic                   x_valid;
  logic                   ready;
  logic [AW-1:0]          rom_addr;
  logic signed [Wc-1:0]   rom_data;
  logic signed [Wacc-1:0] y_out;
  logic                   y_valid;

  modport master (
    input  x_in, x_valid, rom_data,
    output ready, rom_addr, y_out, y_valid
  );

  modport slave (
    output x_in, x_valid, rom_data,
    input  ready, rom_addr, y_out, y_valid
  );

endinterface

// File: rtl/fir_sample_buf.sv
// fir_sample_buf
//   Circular history of the last Num_coef input samples. One synchronous
//   write port, one asynchronous read port; every slot clears on reset so a
//   fresh run starts with an all-zero history.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     wr_en     write wr_data into slot wr_addr on the rising edge
//     wr_addr   AW-bit write slot
//     wr_data   Win-bit signed sample
//     rd_addr   AW-bit read slot
//     rd_data   Win-bit signed sample at rd_addr (combinational)
module fir_sample_buf #(
  parameter int Win      = 16,
  parameter int Num_coef = 17,
  parameter int AW       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic signed [Win-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic signed [Win-1:0] rd_data
);

  logic signed [Win-1:0] mem [Num_coef];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Num_coef; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_coef_mac_seq.sv
// fir_coef_mac_seq
//   Serial FIR engine sharing one multiply-accumulate across all taps. For
//   each accepted sample it sweeps the coefficient ROM addresses 0..Num_coef-1,
//   multiplies each coefficient with the matching delayed sample and emits one
//   full-precision result.
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     bus        fir_coef_mac_seq_if.master (sample in, ROM read, result out)
//     dbg_state  current FSM state
//   Timing: accept on edge 0, rom_addr=k during cycle k (k=0..Num_coef-1),
//   y_valid pulses Num_coef+2 cycles after the accept edge; a new sample can
//   be taken every Num_coef+3 cycles.
module fir_coef_mac_seq
  import fir_pkg::*;
#(
  parameter int Wc       = DEF_WC,
  parameter int Num_coef = DEF_NUM_COEF,
  parameter int Win      = DEF_WIN
) (
  input  logic               clk,
  input  logic               rst,
  fir_coef_mac_seq_if.master bus,
  output state_t             dbg_state
);

  localparam int AW   = clog2(Num_coef);
  localparam int Wp   = Win + Wc;
  localparam int Wacc = Wp + AW;
  localparam logic [AW-1:0] LAST = AW'(Num_coef - 1);

  state_t                 state;
  logic [AW-1:0]          tap;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_idx;
  logic signed [Win-1:0]  rd_data;
  logic signed [Win-1:0]  x_reg;
  logic signed [Wp-1:0]   prod;
  logic signed [Wacc-1:0] acc;
  logic                   mac_en;
  logic                   accept;

  assign dbg_state = state;
  assign accept    = (state == IDLE) && bus.x_valid;

  // x[n-k] lives at (wr_ptr - k) mod Num_coef. Done with a compare instead
  // of bit wrap so a non-power-of-two depth never produces a slot >= Num_coef.
  always_comb begin
    rd_idx = wr_ptr - tap;
    if (wr_ptr < tap) rd_idx = wr_ptr + AW'(Num_coef) - tap;
  end

  fir_sample_buf #(
    .Win      (Win),
    .Num_coef (Num_coef),
    .AW       (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.x_in),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  // x_reg and rom_data both refer to the tap addressed one cycle earlier
  assign prod = Wp'(x_reg) * Wp'(bus.rom_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.ready    <= 1'b1;
      bus.rom_addr <= '0;
      bus.y_out    <= '0;
      bus.y_valid  <= 1'b0;
      tap          <= '0;
      wr_ptr       <= '0;
      x_reg        <= '0;
      mac_en       <= 1'b0;
      acc          <= '0;
    end else begin
      bus.y_valid <= 1'b0;
      x_reg       <= rd_data;
      // a product is available the cycle after each RUN cycle
      mac_en      <= (state == RUN);
      if (mac_en) acc <= acc + Wacc'(prod);

      case (state)
        IDLE: begin
          if (bus.x_valid) begin
            state        <= RUN;
            bus.ready    <= 1'b0;
            tap          <= '0;
            bus.rom_addr <= '0;
            acc          <= '0;
          end
        end
        RUN: begin
          if (tap == LAST) begin
            state <= DRAIN;
          end else begin
            tap          <= tap + 1'b1;
            bus.rom_addr <= tap + 1'b1;
          end
        end
        DRAIN: begin
          state <= DONE;
        end
        DONE: begin
          state       <= IDLE;
          bus.ready   <= 1'b1;
          bus.y_out   <= acc;
          bus.y_valid <= 1'b1;
          wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_mac_seq.sv
// tb_fir_coef_mac_seq
//   Bench for the serial FIR engine. A registered coefficient ROM model feeds
//   the DUT; a reference model computes each output as sum(coef[k]*x[n-k])
//   over the accepted-sample history and predicts when ready, rom_addr and
//   y_valid must be seen. Directed tests add literal checks on the outputs.
module tb_fir_coef_mac_seq;
  import fir_pkg::*;

  localparam int WC   = 18;
  localparam int NC   = 17;
  localparam int WIN  = 16;
  localparam int WACC = WIN + WC + 5;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  fir_coef_mac_seq_if #(.Wc(WC), .Num_coef(NC), .Win(WIN)) bus ();

  fir_coef_mac_seq #(.Wc(WC), .Num_coef(NC), .Win(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- registered coefficient ROM ----------------
  logic signed [WC-1:0] coef [NC];

  always @(posedge clk) bus.rom_data <= coef[bus.rom_addr];

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc        = 0;      // rising edges since start (outside reset)
  int acc_edge   = -1000;  // edge of the last accepted sample
  int model_addr = 0;
  logic signed [WIN-1:0]  hist[$];   // newest first
  logic signed [WACC-1:0] exp_q[$];
  int                     exp_t[$];
  longint                 got_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      exp_q.delete();
      exp_t.delete();
      acc_edge   = -1000;
      model_addr = 0;
    end else begin
      // engine is free once NC+3 cycles have passed since the last accept
      if (bus.x_valid && (cyc - acc_edge >= NC + 3)) begin
        longint y;
        acc_edge = cyc;
        hist.push_front(bus.x_in);
        if (hist.size() > NC) void'(hist.pop_back());
        y = 0;
        for (int k = 0; k < hist.size(); k++)
          y += longint'(coef[k]) * longint'(hist[k]);
        exp_q.push_back(WACC'(y));
        exp_t.push_back(cyc + NC + 2);
      end
      if (cyc - acc_edge <= NC - 1) model_addr = cyc - acc_edge;
      cyc++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      int  last_edge;
      logic exp_vld;
      last_edge = cyc - 1;
      exp_vld   = (exp_t.size() > 0) && (exp_t[0] == last_edge);
      chk("ready", longint'(bus.ready), longint'(last_edge - acc_edge >= NC + 2));
      chk("rom_addr", longint'(bus.rom_addr), longint'(model_addr));
      chk("y_valid", longint'(bus.y_valid), longint'(exp_vld));
      if (bus.y_valid) got_q.push_back(longint'(bus.y_out));
      if (exp_vld) begin
        if (bus.y_valid) chk("y_out", longint'(bus.y_out), longint'(exp_q[0]));
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic signed [WIN-1:0] x);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: ready stayed 0 for %0d cycles", n);
    end
    bus.x_in    = x;
    bus.x_valid = 1'b1;
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  task automatic chk_got(input string name, input int idx, input longint exp);
    if (idx < got_q.size()) begin
      chk(name, got_q[idx], exp);
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: only %0d results, expected %0d at index %0d", name, got_q.size(), exp, idx);
    end
  endtask

  task automatic set_ramp_coefs();
    for (int k = 0; k < NC; k++) coef[k] = WC'(k + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int pulses;
    int pulse_at;
    set_ramp_coefs();
    bus.x_in    = '0;
    bus.x_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_ready",    longint'(bus.ready),    1);
    chk("rst_y_out",    longint'(bus.y_out),    0);
    chk("rst_y_valid",  longint'(bus.y_valid),  0);
    chk("rst_rom_addr", longint'(bus.rom_addr), 0);
    chk("rst_state",    longint'(dbg_state),    longint'(IDLE));

    // impulse: outputs walk the coefficient list, then fall to zero
    got_q.delete();
    send(16'sd1);
    for (int i = 0; i < NC; i++) send(16'sd0);
    drain();
    for (int i = 0; i < NC; i++) chk_got("impulse", i, longint'(i + 1));
    chk_got("impulse_tail", NC, 0);

    // step: buffer wraps several times, output settles at 1+2+...+17
    got_q.delete();
    for (int i = 0; i < 40; i++) send(16'sd1);
    drain();
    chk_got("step_first", 0, 1);
    chk_got("step_ramp", 1, 3);
    chk_got("step_settle", 16, 153);
    chk_got("step_last", 39, 153);

    // latency, rom_addr sweep and dropped samples while busy
    send(16'sd3);
    pulses   = 0;
    pulse_at = -1;
    for (int c = 0; c <= 24; c++) begin
      if (c < NC) chk("addr_sweep", longint'(bus.rom_addr), longint'(c));
      if (bus.y_valid) begin
        pulses++;
        pulse_at = c;
      end
      // c=18 is the DONE cycle: a strobe there must not be taken either
      if (c == 3 || c == 9 || c == 16 || c == 18) begin
        bus.x_in    = WIN'($urandom_range(0, 65535));
        bus.x_valid = 1'b1;
      end else begin
        bus.x_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.x_valid = 1'b0;
    chk("latency_pulses", pulses, 1);
    chk("latency_cycle", pulse_at, 19);
    chk("addr_hold", longint'(bus.rom_addr), 16);
    drain();

    // extremes: largest-magnitude product on every tap
    for (int k = 0; k < NC; k++) coef[k] = -18'sd131072;
    got_q.delete();
    for (int i = 0; i < 20; i++) send(-16'sd32768);
    drain();
    chk_got("extreme_16", 16, 64'sd73014444032);
    chk_got("extreme_19", 19, 64'sd73014444032);
    set_ramp_coefs();

    // reset in the middle of a run, history must be gone afterwards
    send(16'sd5);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("mid_addr", longint'(bus.rom_addr), 8);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready",   longint'(bus.ready),    1);
    chk("mid_rst_y_out",   longint'(bus.y_out),    0);
    chk("mid_rst_y_valid", longint'(bus.y_valid),  0);
    chk("mid_rst_addr",    longint'(bus.rom_addr), 0);
    chk("mid_rst_state",   longint'(dbg_state),    longint'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    send(16'sd1);
    send(16'sd0);
    drain();
    chk_got("post_rst_impulse0", 0, 1);
    chk_got("post_rst_impulse1", 1, 2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
